// File: rtl/fan_pkg.sv
// rtl/fan_pkg.sv - shared fan duty widths, preset duties and driver state encoding
package fan_pkg;

    localparam int DUTY_W = 7;
    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(100);

    // Presets shared with the speed selector; LOW doubles as the kick-start floor
    localparam logic [DUTY_W-1:0] DUTY_OFF  = DUTY_W'(0);
    localparam logic [DUTY_W-1:0] DUTY_LOW  = DUTY_W'(30);
    localparam logic [DUTY_W-1:0] DUTY_MID  = DUTY_W'(60);
    localparam logic [DUTY_W-1:0] DUTY_HIGH = DUTY_W'(90);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        KICK = 2'd3
    } fan_state_e;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    function automatic logic is_preset(input logic [DUTY_W-1:0] d);
        return (d == DUTY_OFF) || (d == DUTY_LOW) || (d == DUTY_MID) || (d == DUTY_HIGH);
    endfunction

endpackage

// File: rtl/fan_pwm_driver_if.sv
// rtl/fan_pwm_driver_if.sv - duty command in, PWM pin and status out
interface fan_pwm_driver_if;
    import fan_pkg::*;

    logic [DUTY_W-1:0] duty;
    logic              pwm_out;
    logic [DUTY_W-1:0] duty_active;
    logic              busy;
    logic              period_start;

    modport master (
        output duty,
        input  pwm_out,
        input  duty_active,
        input  busy,
        input  period_start
    );

    modport slave (
        input  duty,
        output pwm_out,
        output duty_active,
        output busy,
        output period_start
    );

endinterface

// File: rtl/fan_pwm_timebase.sv
// rtl/fan_pwm_timebase.sv - PWM prescaler and step counter with period boundary strobe
module fan_pwm_timebase #(
    parameter int PRESCALE = 1000,
    parameter int STEPS    = 100
) (
    input  logic                     clk,
    input  logic                     reset_p,
    output logic [$clog2(STEPS)-1:0] step_cnt,
    output logic [$clog2(STEPS)-1:0] step_nxt,
    output logic                     step_tick,
    output logic                     boundary
);

    localparam int SW = $clog2(STEPS);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS - 1);

    logic [PW-1:0] presc_cnt;

    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            presc_cnt <= '0;
            step_cnt  <= '0;
        end else begin
            presc_cnt <= step_tick ? '0 : presc_cnt + 1'b1;
            step_cnt  <= step_nxt;
        end
    end

    always_comb begin
        step_tick = (presc_cnt == PRESC_LAST);
        boundary  = step_tick && (step_cnt == STEP_LAST);
        step_nxt  = step_cnt;
        if (step_tick) begin
            step_nxt = (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fan_pwm_driver.sv
// rtl/fan_pwm_driver.sv - soft-start fan PWM driver; FAN_PWM_KICKSTART_EN adds a 4-period full-on kick
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int SYS_CLK_HZ   = 100_000_000,
    parameter int PWM_HZ       = 1_000,
    parameter int PRESCALE     = SYS_CLK_HZ / (PWM_HZ * 100),
    parameter int RAMP_PERIODS = 10
) (
    input  logic             clk,
    input  logic             reset_p,
    fan_pwm_driver_if.slave  bus
);

    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_PERIODS - 1);

    logic [DUTY_W-1:0] step_cnt;
    logic [DUTY_W-1:0] step_nxt;
    logic              step_tick;
    logic              boundary;
    logic              timebase_unused;

    fan_state_e        state;
    fan_state_e        state_nxt;
    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_nxt;
    logic [RW-1:0]     rp_cnt;
    logic [RW-1:0]     rp_nxt;
    logic              pwm_q;
    logic              pwm_nxt;
    logic              busy_q;
    logic              busy_nxt;
    logic              pstart_q;
    logic              first_q;
`ifdef FAN_PWM_KICKSTART_EN
    logic [1:0]        kick_cnt;
    logic [1:0]        kick_nxt;
`endif

    fan_pwm_timebase #(
        .PRESCALE (PRESCALE),
        .STEPS    (100)
    ) u_timebase (
        .clk       (clk),
        .reset_p   (reset_p),
        .step_cnt  (step_cnt),
        .step_nxt  (step_nxt),
        .step_tick (step_tick),
        .boundary  (boundary)
    );

    // step_cnt/step_tick serve other timebase users; the pin is driven from step_nxt
    assign timebase_unused = step_tick ^ (^step_cnt);

    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            state    <= IDLE;
            tgt      <= '0;
            duty_q   <= '0;
            rp_cnt   <= '0;
            pwm_q    <= 1'b0;
            busy_q   <= 1'b0;
            pstart_q <= 1'b0;
            first_q  <= 1'b1;
`ifdef FAN_PWM_KICKSTART_EN
            kick_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            tgt      <= clamp_duty(bus.duty);
            duty_q   <= duty_nxt;
            rp_cnt   <= rp_nxt;
            pwm_q    <= pwm_nxt;
            busy_q   <= busy_nxt;
            pstart_q <= boundary | first_q;
            first_q  <= 1'b0;
`ifdef FAN_PWM_KICKSTART_EN
            kick_cnt <= kick_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_q;
        rp_nxt    = rp_cnt;
`ifdef FAN_PWM_KICKSTART_EN
        kick_nxt  = kick_cnt;
`endif
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (tgt != '0) begin
                        rp_nxt = '0;
`ifdef FAN_PWM_KICKSTART_EN
                        state_nxt = KICK;
                        kick_nxt  = '0;
                        duty_nxt  = DUTY_MAX;
`else
                        state_nxt = RAMP;
`endif
                    end
                end
                RAMP: begin
                    if (rp_cnt == RAMP_LAST) begin
                        rp_nxt = '0;
                        if (duty_q < tgt) begin
                            duty_nxt = duty_q + 1'b1;
                        end else if (duty_q > tgt) begin
                            duty_nxt = duty_q - 1'b1;
                        end
                        if (duty_nxt == tgt) begin
                            state_nxt = (tgt == '0) ? IDLE : HOLD;
                        end
                    end else begin
                        rp_nxt = rp_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (tgt != duty_q) begin
                        state_nxt = RAMP;
                        rp_nxt    = '0;
                    end
                end
                KICK: begin
`ifdef FAN_PWM_KICKSTART_EN
                    if (tgt == '0) begin
                        state_nxt = IDLE;
                        duty_nxt  = '0;
                    end else if (kick_cnt == 2'd3) begin
                        duty_nxt  = (tgt > DUTY_LOW) ? tgt : DUTY_LOW;
                        state_nxt = (duty_nxt == tgt) ? HOLD : RAMP;
                        rp_nxt    = '0;
                    end else begin
                        kick_nxt = kick_cnt + 1'b1;
                    end
`else
                    state_nxt = IDLE;
                    duty_nxt  = '0;
`endif
                end
                default: begin
                    state_nxt = IDLE;
                    duty_nxt  = '0;
                end
            endcase
        end
    end

    // Compare against next-cycle values so the registered pin lines up with step_cnt
    always_comb begin
        pwm_nxt  = (step_nxt < duty_nxt);
        busy_nxt = (state_nxt == RAMP);
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.duty_active  = duty_q;
    assign bus.busy         = busy_q;
    assign bus.period_start = pstart_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// tb/tb_fan_pwm_driver.sv - scoreboard bench for fan_pwm_driver, default build
`timescale 1ns/1ps
module tb_fan_pwm_driver;
    import fan_pkg::*;

    localparam int PRESC = 2;
    localparam int PER   = PRESC * 100;

    typedef struct packed {
        logic [6:0] da;
        logic       busy;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_p = 1'b0;
    int   checks  = 0;
    int   fails   = 0;
    exp_t sb[$];

    fan_pwm_driver_if bus();

    fan_pwm_driver #(
        .SYS_CLK_HZ   (200),
        .PWM_HZ       (1),
        .RAMP_PERIODS (1)
    ) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One scoreboard entry per PWM period: applied duty and busy for that period
    int cyc     = 0;
    int last_ps = 0;
    int npulse  = 0;
    int hi      = 0;
    int prev_da = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_p) begin
            npulse = 0;
            hi     = 0;
        end else if (bus.period_start) begin
            if (npulse >= 1) check("high_time", hi, PRESC * prev_da);
            if (npulse >= 2) check("period_len", cyc - last_ps, PER);
            last_ps = cyc;
            npulse++;
            hi = bus.pwm_out ? 1 : 0;
            check("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("duty_active", bus.duty_active, e.da);
                check("busy", bus.busy, e.busy);
                prev_da = e.da;
            end
        end else begin
            hi += bus.pwm_out ? 1 : 0;
        end
    end

    task automatic push_exp(input int da, input bit busy);
        exp_t e;
        e.da   = 7'(da);
        e.busy = busy;
        sb.push_back(e);
    endtask

    // First period after a target change still shows the old duty, then 1 % per period
    task automatic push_ramp(input int from, input int to, input bit end_busy);
        int d;
        d = from;
        push_exp(from, 1'b1);
        while (d != to) begin
            d += (to > d) ? 1 : -1;
            push_exp(d, (d != to) ? 1'b1 : end_busy);
        end
    endtask

    task automatic wait_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.period_start && t < 3 * PER);
            if (!bus.period_start) begin
                checks++;
                fails++;
                $display("FAIL pulse_timeout: no period_start within %0d clocks", 3 * PER);
            end
            #2;
        end
    endtask

    initial begin
        bus.duty = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm_out", bus.pwm_out, 0);
        check("rst_duty_active", bus.duty_active, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_period_start", bus.period_start, 0);

        repeat (5) push_exp(0, 1'b0);
        @(posedge clk);
        #2 reset_p = 1'b1;
        wait_pulses(5);

        bus.duty = 7'd30;
        push_ramp(0, 30, 1'b0);
        wait_pulses(31);
        repeat (2) push_exp(30, 1'b0);
        wait_pulses(2);

        bus.duty = 7'd90;
        push_ramp(30, 90, 1'b0);
        wait_pulses(61);

        bus.duty = 7'd127;
        push_ramp(90, 100, 1'b0);
        repeat (2) push_exp(100, 1'b0);
        wait_pulses(13);

        bus.duty = 7'd60;
        push_ramp(100, 60, 1'b0);
        wait_pulses(41);

        repeat (50) @(posedge clk);
        #3;
        check("pwm_high_before_reset", bus.pwm_out, 1);
        reset_p = 1'b0;
        #1;
        check("async_rst_pwm_out", bus.pwm_out, 0);
        check("async_rst_duty_active", bus.duty_active, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_period_start", bus.period_start, 0);

        bus.duty = 7'd90;
        push_exp(0, 1'b0);
        push_ramp(0, 45, 1'b1);
        repeat (3) @(posedge clk);
        #2 reset_p = 1'b1;
        wait_pulses(47);

        bus.duty = 7'd30;
        push_ramp(44, 30, 1'b0);
        push_exp(30, 1'b0);
        wait_pulses(16);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
